read_resp_merge: RTL

READ_RESP_MERGE -- requirements
Module: read_resp_merge

---
 rtl/read_resp_merge.sv | 93 +++++++++
 1 files changed

// File: rtl/read_resp_merge.sv
// read_resp_merge: merges eight RAM read-return streams onto four lanes through per-RAM FIFOs with credit return
module read_resp_merge #(
  parameter int PLD_W      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            ram_rd_vld,
  input  logic [7:0][PLD_W-1:0] ram_rd_pld,
  output logic [7:0]            ram_rd_credit,
  output logic [3:0]            lane_rd_vld,
  input  logic [3:0]            lane_rd_rdy,
  output logic [3:0][PLD_W-1:0] lane_rd_pld,
  output logic [3:0]            lane_rd_src,
  output logic [7:0]            ovf_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);
  logic [PLD_W-1:0] r_mem [8][FIFO_DEPTH];
  logic [AW-1:0]    r_wp  [8];
  logic [AW-1:0]    r_rp  [8];
  logic [AW:0]      r_cnt [8];
  logic [7:0]       r_credit, r_ovf;
  logic [7:0]       w_ne, w_full, w_push, w_pop;
  logic [3:0]       r_rr, r_lock, r_lsel, w_sel;
  // A full FIFO still takes a push when it pops in the same cycle
  assign w_push        = ram_rd_vld & (~w_full | w_pop);
  assign ram_rd_credit = r_credit;
  assign ovf_err       = r_ovf;
  // Per-RAM FIFO occupancy flags
  always_comb begin
    w_ne   = '0;
    w_full = '0;
    for (int j = 0; j < 8; j++) begin
      w_ne[j]   = r_cnt[j] != '0;
      w_full[j] = r_cnt[j] == FULL;
    end
  end
  // Lane arbitration: hold the choice while stalled, otherwise round-robin between the even/odd RAM pair
  always_comb begin
    w_sel       = '0;
    w_pop       = '0;
    lane_rd_vld = '0;
    lane_rd_src = '0;
    lane_rd_pld = '0;
    for (int i = 0; i < 4; i++) begin
      lane_rd_vld[i] = w_ne[2*i] || w_ne[2*i+1];
      w_sel[i]       = r_lock[i] ? r_lsel[i] : (w_ne[2*i] && w_ne[2*i+1]) ? r_rr[i] : w_ne[2*i+1];
      lane_rd_src[i] = lane_rd_vld[i] && w_sel[i];
      lane_rd_pld[i] = !lane_rd_vld[i] ? '0 : w_sel[i] ? r_mem[2*i+1][r_rp[2*i+1]] : r_mem[2*i][r_rp[2*i]];
      w_pop[2*i]     = lane_rd_vld[i] && lane_rd_rdy[i] && !w_sel[i];
      w_pop[2*i+1]   = lane_rd_vld[i] && lane_rd_rdy[i] && w_sel[i];
    end
  end
  // FIFO pointers and counts, one credit pulse per pop, sticky overflow on dropped pushes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < 8; j++) begin
        r_wp[j]  <= '0;
        r_rp[j]  <= '0;
        r_cnt[j] <= '0;
      end
      r_credit <= '0;
      r_ovf    <= '0;
    end else begin
      for (int j = 0; j < 8; j++) begin
        r_wp[j]  <= r_wp[j] + AW'(w_push[j]);
        r_rp[j]  <= r_rp[j] + AW'(w_pop[j]);
        r_cnt[j] <= r_cnt[j] + (AW+1)'(w_push[j]) - (AW+1)'(w_pop[j]);
      end
      r_credit <= w_pop;
      r_ovf    <= r_ovf | (ram_rd_vld & w_full & ~w_pop);
    end
  end
  // Payload storage; validity is tracked by the counts so the array needs no reset
  always_ff @(posedge clk) begin
    for (int j = 0; j < 8; j++)
      if (w_push[j]) r_mem[j][r_wp[j]] <= ram_rd_pld[j];
  end
  // Round-robin pointer flips away from the popped side; stall lock remembers the presented choice
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr   <= '0;
      r_lock <= '0;
      r_lsel <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (lane_rd_vld[i] && lane_rd_rdy[i]) r_rr[i] <= !w_sel[i];
      r_lock <= lane_rd_vld & ~lane_rd_rdy;
      r_lsel <= w_sel;
    end
  end
endmodule
